// File: rtl/cache_axi_wr_sched_if.sv
// Handshake/select bundle between the write scheduler, the cache requesters and the AXI master port.
// The scheduler sits on the slave modport; whatever drives requesters and memory uses master.
interface cache_axi_wr_sched_if #(
  parameter int NumPorts       = 3,
  parameter int IdWidth        = 4,
  parameter int MaxOutstanding = 4
);
  localparam int CntW = $clog2(MaxOutstanding) + 1;

  logic [NumPorts-1:0] req_aw_valid_i;
  logic [NumPorts-1:0] req_aw_ready_o;
  logic                mem_aw_valid_o;
  logic                mem_aw_ready_i;
  logic [1:0]          mem_aw_sel_o;

  logic [NumPorts-1:0] req_w_valid_i;
  logic [NumPorts-1:0] req_w_last_i;
  logic [NumPorts-1:0] req_w_ready_o;
  logic                mem_w_valid_o;
  logic                mem_w_last_o;
  logic                mem_w_ready_i;
  logic [1:0]          mem_w_sel_o;

  logic                mem_b_valid_i;
  logic [IdWidth-1:0]  mem_b_id_i;
  logic                mem_b_ready_o;
  logic [NumPorts-1:0] req_b_valid_o;
  logic [NumPorts-1:0] req_b_ready_i;

  logic [CntW-1:0]     outstanding_o;
  logic                busy_o;
  logic                err_o;

  modport slave (
    input  req_aw_valid_i, mem_aw_ready_i,
    input  req_w_valid_i, req_w_last_i, mem_w_ready_i,
    input  mem_b_valid_i, mem_b_id_i, req_b_ready_i,
    output req_aw_ready_o, mem_aw_valid_o, mem_aw_sel_o,
    output req_w_ready_o, mem_w_valid_o, mem_w_last_o, mem_w_sel_o,
    output mem_b_ready_o, req_b_valid_o,
    output outstanding_o, busy_o, err_o
  );

  modport master (
    output req_aw_valid_i, mem_aw_ready_i,
    output req_w_valid_i, req_w_last_i, mem_w_ready_i,
    output mem_b_valid_i, mem_b_id_i, req_b_ready_i,
    input  req_aw_ready_o, mem_aw_valid_o, mem_aw_sel_o,
    input  req_w_ready_o, mem_w_valid_o, mem_w_last_o, mem_w_sel_o,
    input  mem_b_ready_o, req_b_valid_o,
    input  outstanding_o, busy_o, err_o
  );
endinterface

// File: rtl/cache_axi_wr_sched.sv
// AXI write-path scheduler: round-robin AW arbitration, grant-ordered W steering, ID-based B return.
// Only handshakes and mux selects live here; payload muxing is done by the surrounding datapath.
module cache_axi_wr_sched #(
  parameter int NumPorts       = 3,
  parameter int IdWidth        = 4,
  parameter int MaxOutstanding = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  cache_axi_wr_sched_if.slave bus
);
  localparam int CntW = $clog2(MaxOutstanding) + 1;
  localparam int PtrW = $clog2(MaxOutstanding);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [1:0]        lock_sel_q, lock_sel_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        fifo_q [MaxOutstanding];
  logic [1:0]        fifo_d [MaxOutstanding];
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              fifo_empty, fifo_full, can_issue;
  logic [1:0]        head;
  logic              found;
  logic [1:0]        win;
  logic [2:0]        sum;
  logic              aw_valid, aw_hs;
  logic [1:0]        aw_sel;
  logic [NumPorts-1:0] aw_ready_vec;
  logic              w_valid, w_last, w_pop, w_err;
  logic [1:0]        w_sel;
  logic [NumPorts-1:0] w_ready_vec;
  logic [1:0]        b_dst;
  logic [NumPorts-1:0] b_valid_vec;
  logic              b_ready, b_hs;
  logic              unused_id_bits;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign can_issue  = !fifo_full && (cnt_q < CntW'(MaxOutstanding));
  assign head       = fifo_q[rd_ptr_q[PtrW-1:0]];

  // Search starts one past the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    sum   = 3'd0;
    for (int k = 1; k <= NumPorts; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'(NumPorts)) sum = sum - 3'(NumPorts);
      if (!found && bus.req_aw_valid_i[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
  end

  // LOCKED keeps the presented AW stable until memory accepts it.
  always_comb begin
    aw_valid     = 1'b0;
    aw_sel       = 2'd0;
    aw_ready_vec = '0;
    if (state_q == ST_LOCKED) begin
      aw_valid = 1'b1;
      aw_sel   = lock_sel_q;
    end else if (can_issue && found) begin
      aw_valid = 1'b1;
      aw_sel   = win;
    end
    if (rst_i) begin
      aw_valid = 1'b0;
      aw_sel   = 2'd0;
    end
    if (aw_valid) aw_ready_vec[aw_sel] = bus.mem_aw_ready_i;
  end

  assign aw_hs = aw_valid && bus.mem_aw_ready_i;

  always_comb begin
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_sel       = 2'd0;
    w_ready_vec = '0;
    if (!fifo_empty) begin
      w_sel             = head;
      w_valid           = bus.req_w_valid_i[head];
      w_last            = bus.req_w_last_i[head];
      w_ready_vec[head] = bus.mem_w_ready_i;
    end
  end

  assign w_pop = w_valid && bus.mem_w_ready_i && w_last;
  assign w_err = w_valid && bus.mem_w_ready_i && fifo_empty;

  always_comb begin
    case (bus.mem_b_id_i[IdWidth-1 -: 2])
      2'b11:   b_dst = 2'd0;
      2'b10:   b_dst = 2'd1;
      default: b_dst = 2'd2;
    endcase
    b_valid_vec        = '0;
    b_valid_vec[b_dst] = bus.mem_b_valid_i && !rst_i;
    b_ready            = bus.req_b_ready_i[b_dst] && !rst_i;
  end

  assign b_hs           = bus.mem_b_valid_i && b_ready;
  assign unused_id_bits = ^bus.mem_b_id_i[IdWidth-3:0];

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    rr_d       = rr_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (aw_hs) begin
      state_d                         = ST_IDLE;
      rr_d                            = aw_sel;
      fifo_d[wr_ptr_q[PtrW-1:0]]      = aw_sel;
      wr_ptr_d                        = wr_ptr_q + (PtrW+1)'(1);
    end else if (aw_valid && state_q == ST_IDLE) begin
      state_d    = ST_LOCKED;
      lock_sel_d = aw_sel;
    end
    if (w_pop) rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    case ({aw_hs, b_hs})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (b_hs && cnt_q == '0) err_d = 1'b1;
    if (w_err) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 2'd0;
      rr_q       <= 2'd0;
      fifo_q     <= '{default: 2'd0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rr_q       <= rr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_aw_valid_o = aw_valid;
  assign bus.mem_aw_sel_o   = aw_sel;
  assign bus.req_aw_ready_o = aw_ready_vec;
  assign bus.mem_w_valid_o  = w_valid;
  assign bus.mem_w_last_o   = w_last;
  assign bus.mem_w_sel_o    = w_sel;
  assign bus.req_w_ready_o  = w_ready_vec;
  assign bus.req_b_valid_o  = b_valid_vec;
  assign bus.mem_b_ready_o  = b_ready;
  assign bus.outstanding_o  = cnt_q;
  assign bus.busy_o         = (cnt_q != '0) || !fifo_empty;
  assign bus.err_o          = err_q;
endmodule
